soma_lif_array: RTL and testbench
=================================

SOMA_LIF_ARRAY -- requirements
Module: soma_lif_array

Interface
REQ-001 SHALL have parameter N_IN, default 4: number of synaptic input channels (1..16).
REQ-002 SHALL have parameter WW, default 8: signed weight width per channel.
REQ-003 SHALL have parameter VW, default 16: unsigned membrane-potential width.
REQ-004 SHALL have parameter TW, default 8: refractory/axon-delay timer width.
REQ-005 SHALL have one clock and synchronous active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-006 SHALL have ports: kill  in  1  permanent deactivation request; cfg_we  in  1  latch configuration inputs.
REQ-007 SHALL have ports: V_rest, V_th, V_leak  in  VW  rest potential, threshold, per-cycle leak; refr_time, axon_delay  in  TW  refractory and axon-delay lengths in cycles.
REQ-008 SHALL have ports: in_spike  in  N_IN  per-channel spike strobes; weight  in  N_IN*WW  packed signed weights, channel i at bits [i*WW +: WW].
REQ-009 SHALL have ports: out_spike  out  1  delayed fire pulse; o_wait  out  1  refractory indicator; o_ovr  out  1  sticky delayed-spike overrun; v_mem  out  VW  current potential.

Function
REQ-010 SHALL hold an FSM with states ACTIVE, REFRACTORY, DEACTIVE.
REQ-011 In ACTIVE, each cycle: sum = signed sum of weight[i] for every i with in_spike[i]=1, width WW+clog2(N_IN)+1; v_next = v + sum - V_leak in signed VW+2 bits; v_next clamped to [V_rest, 2^VW-1].
REQ-012 Fire condition: v_next >= V_th in ACTIVE; on fire, v <= V_rest, state <= REFRACTORY, refractory counter <= refr_time; otherwise v <= v_next.
REQ-013 In REFRACTORY: in_spike ignored, v held at V_rest, o_wait = 1; counter decrements each cycle; cycle where counter = 0 returns to ACTIVE; total REFRACTORY duration = refr_time+1 cycles (refr_time=0 -> one cycle).
REQ-014 Axon delay: fire at cycle t SHALL produce exactly one out_spike pulse, one cycle wide, at cycle t+1+axon_delay, independent of FSM state except DEACTIVE.
REQ-015 Only one delayed spike SHALL be pending; a fire while one is pending SHALL be dropped (pending pulse unaffected) and set o_ovr, which stays 1 until rst.
REQ-016 Pending pulse expiring in the same cycle as a new fire: pulse emitted, new fire accepted as pending, o_ovr unchanged.
REQ-017 kill = 1 in any state SHALL move to DEACTIVE next cycle, clear pending spike, force out_spike = 0 and o_wait = 0, freeze v; DEACTIVE exits only via rst.
REQ-018 cfg_we = 1 SHALL latch V_rest, V_th, V_leak, refr_time, axon_delay at the clock edge; values take effect next cycle; same-cycle fire/leak uses previously latched values.
REQ-019 Computations SHALL use only latched configuration, never live config inputs (except at reset).
REQ-020 v_mem SHALL be the registered v; all outputs registered.

Reset
REQ-021 rst = 1 SHALL force state ACTIVE, latch all config inputs, v <= V_rest input, counters 0, no pending spike, out_spike = 0, o_wait = 0, o_ovr = 0.
REQ-022 rst SHALL take priority over kill, cfg_we and fire in the same cycle; reset mid-refractory or mid-delay discards that activity.

Verification (N_IN=4, WW=8, VW=16, TW=8)
REQ-023 Integrate/fire: V_rest=0, V_th=100, V_leak=2, all weights 30, in_spike=4'b0011 continuous from cycle 0 -> v_mem 58 after cycle 0, fire on cycle 1, v_mem=0, o_wait=1 from cycle 2.
REQ-024 Delay/refractory: as REQ-023 with axon_delay=3, refr_time=2 -> out_spike single pulse at cycle 5; o_wait high cycles 2-4; ACTIVE resumes cycle 5.
REQ-025 Clamp: weights -50, in_spike=4'b1111, V_rest=10 -> v_mem stays 10, no fire; weights 127, V_th=65535 -> v_mem saturates 65535 and fires.
REQ-026 Overrun: refr_time=0, axon_delay=10, strong input -> second fire within 10 cycles sets o_ovr=1, exactly one out_spike per accepted fire.
REQ-027 Kill: assert kill for one cycle with spike pending -> no out_spike ever, o_wait=0, v_mem frozen; rst returns to ACTIVE with v_mem=V_rest.
REQ-028 Config: cfg_we with V_th=40 in the cycle v_next=50 against old V_th=100 -> no fire that cycle; fire next cycle if v_next >= 40.

Source files
------------

// File: rtl/soma_lif_array_if.sv
// Bundles the soma's configuration, synaptic input and output signals.
//   master : drives kill, cfg_we, config values, in_spike and weight;
//            observes out_spike, o_wait, o_ovr and v_mem.
//   slave  : the soma itself, with the opposite directions.
interface soma_lif_array_if #(
  parameter int N_IN = 4,
  parameter int WW   = 8,
  parameter int VW   = 16,
  parameter int TW   = 8
);
  logic                 kill;
  logic                 cfg_we;
  logic [VW-1:0]        V_rest;
  logic [VW-1:0]        V_th;
  logic [VW-1:0]        V_leak;
  logic [TW-1:0]        refr_time;
  logic [TW-1:0]        axon_delay;
  logic [N_IN-1:0]      in_spike;
  logic [N_IN*WW-1:0]   weight;
  logic                 out_spike;
  logic                 o_wait;
  logic                 o_ovr;
  logic [VW-1:0]        v_mem;

  modport master (
    output kill, cfg_we, V_rest, V_th, V_leak, refr_time, axon_delay,
           in_spike, weight,
    input  out_spike, o_wait, o_ovr, v_mem
  );

  modport slave (
    input  kill, cfg_we, V_rest, V_th, V_leak, refr_time, axon_delay,
           in_spike, weight,
    output out_spike, o_wait, o_ovr, v_mem
  );
endinterface

// File: rtl/soma_lif_array.sv
// Leaky integrate-and-fire soma with N_IN weighted synaptic channels,
// refractory period, single-slot axon delay line and permanent kill.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : soma_lif_array_if slave modport
//     kill, cfg_we, V_rest/V_th/V_leak, refr_time/axon_delay  (in)
//     in_spike[N_IN], weight[N_IN*WW] packed signed              (in)
//     out_spike, o_wait, o_ovr, v_mem                            (out, registered)

// One synaptic lane: gates a signed weight by its spike strobe and
// sign-extends it to the accumulator width.
module soma_lif_lane #(
  parameter int WW = 8,
  parameter int SW = 11
) (
  input  logic          spike,
  input  logic [WW-1:0] w,
  output logic [SW-1:0] term
);
  assign term = spike ? {{(SW-WW){w[WW-1]}}, w} : '0;
endmodule

module soma_lif_array #(
  parameter int N_IN = 4,
  parameter int WW   = 8,
  parameter int VW   = 16,
  parameter int TW   = 8
) (
  input  logic clk,
  input  logic rst,
  soma_lif_array_if.slave bus
);
  localparam int SW = WW + $clog2(N_IN) + 1;  // synaptic sum width
  localparam int VX = VW + 2;                 // signed membrane update width

  typedef enum logic [1:0] {ACTIVE, REFRACTORY, DEACTIVE} state_t;

  state_t        state;
  logic [VW-1:0] v;
  logic [VW-1:0] lat_rest, lat_th, lat_leak;
  logic [TW-1:0] lat_refr, lat_dly;
  logic [TW-1:0] rcnt;
  logic [TW-1:0] dcnt;
  logic          pend;
  logic          out_spike_q, o_wait_q, o_ovr_q;

  // ---- synaptic integration ----
  logic [N_IN-1:0][SW-1:0] term;

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_lane
    soma_lif_lane #(.WW(WW), .SW(SW)) u_lane (
      .spike (bus.in_spike[gi]),
      .w     (bus.weight[gi*WW +: WW]),
      .term  (term[gi])
    );
  end

  logic signed [SW-1:0] sum;
  logic signed [VX-1:0] v_raw;
  logic        [VW-1:0] v_clamp;
  logic                 fire;
  logic                 expire;

  always_comb begin
    sum = '0;
    for (int i = 0; i < N_IN; i++) sum = sum + term[i];
    v_raw = $signed({2'b00, v}) + $signed({{(VX-SW){sum[SW-1]}}, sum})
            - $signed({2'b00, lat_leak});
    // Floor at the rest potential, ceiling at full scale.
    if (v_raw < $signed({2'b00, lat_rest}))
      v_clamp = lat_rest;
    else if (v_raw > $signed({2'b00, {VW{1'b1}}}))
      v_clamp = '1;
    else
      v_clamp = v_raw[VW-1:0];
    fire   = (state == ACTIVE) && (v_clamp >= lat_th);
    // The pending pulse leaves the delay slot this cycle.
    expire = pend && (dcnt == '0);
  end

  // ---- state, membrane, delay line ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ACTIVE;
      lat_rest    <= bus.V_rest;
      lat_th      <= bus.V_th;
      lat_leak    <= bus.V_leak;
      lat_refr    <= bus.refr_time;
      lat_dly     <= bus.axon_delay;
      v           <= bus.V_rest;
      rcnt        <= '0;
      dcnt        <= '0;
      pend        <= 1'b0;
      out_spike_q <= 1'b0;
      o_wait_q    <= 1'b0;
      o_ovr_q     <= 1'b0;
    end else begin
      if (bus.cfg_we) begin
        lat_rest <= bus.V_rest;
        lat_th   <= bus.V_th;
        lat_leak <= bus.V_leak;
        lat_refr <= bus.refr_time;
        lat_dly  <= bus.axon_delay;
      end
      out_spike_q <= 1'b0;

      if (bus.kill || state == DEACTIVE) begin
        // Dead soma: v frozen, nothing pending, outputs quiet.
        state    <= DEACTIVE;
        pend     <= 1'b0;
        o_wait_q <= 1'b0;
      end else begin
        // Delay slot counts down regardless of soma state.
        if (expire) begin
          out_spike_q <= 1'b1;
          pend        <= 1'b0;
        end else if (pend) begin
          dcnt <= dcnt - 1'b1;
        end

        case (state)
          ACTIVE: begin
            if (fire) begin
              v        <= lat_rest;
              state    <= REFRACTORY;
              rcnt     <= lat_refr;
              o_wait_q <= 1'b1;
              // Slot is free if empty or emptying this very cycle.
              if (!pend || expire) begin
                if (lat_dly == '0) begin
                  out_spike_q <= 1'b1;
                end else begin
                  pend <= 1'b1;
                  // Output is registered, so the countdown is one short.
                  dcnt <= lat_dly - 1'b1;
                end
              end else begin
                o_ovr_q <= 1'b1;
              end
            end else begin
              v        <= v_clamp;
              o_wait_q <= 1'b0;
            end
          end
          REFRACTORY: begin
            v <= lat_rest;
            if (rcnt == '0) begin
              state    <= ACTIVE;
              o_wait_q <= 1'b0;
            end else begin
              rcnt <= rcnt - 1'b1;
            end
          end
          default: state <= DEACTIVE;
        endcase
      end
    end
  end

  assign bus.out_spike = out_spike_q;
  assign bus.o_wait    = o_wait_q;
  assign bus.o_ovr     = o_ovr_q;
  assign bus.v_mem     = v;
endmodule

// File: tb/tb_soma_lif_array.sv
module tb_soma_lif_array;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  soma_lif_array_if #(.N_IN(4), .WW(8), .VW(16), .TW(8)) bus ();

  soma_lif_array #(.N_IN(4), .WW(8), .VW(16), .TW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input logic [7:0] w3, input logic [7:0] w2,
                       input logic [7:0] w1, input logic [7:0] w0);
    bus.weight = {w3, w2, w1, w0};
  endtask

  // Reset with the given configuration presented on the config inputs.
  task automatic do_reset(input int rest, input int th, input int leak,
                          input int refr, input int dly);
    bus.V_rest     = 16'(rest);
    bus.V_th       = 16'(th);
    bus.V_leak     = 16'(leak);
    bus.refr_time  = 8'(refr);
    bus.axon_delay = 8'(dly);
    bus.kill       = 1'b0;
    bus.cfg_we     = 1'b0;
    bus.in_spike   = 4'b0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.weight = '0;
    do_reset(7, 100, 2, 2, 3);
    checks++; if (bus.v_mem !== 16'd7) begin errors++; $display("FAIL reset_v got %0d want 7", bus.v_mem); end
    checks++; if ({bus.out_spike, bus.o_wait, bus.o_ovr} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {bus.out_spike, bus.o_wait, bus.o_ovr}); end
  endtask

  // Integrate, fire, refractory and axon delay across two fires.
  task automatic test_integrate_fire();
    int       exp_v [8] = '{58, 0, 0, 0, 0, 58, 0, 0};
    bit [7:0] exp_w = 8'b1100_1110;  // bit k = o_wait after tick k
    bit [7:0] exp_o = 8'b0001_0000;
    set_w(8'd30, 8'd30, 8'd30, 8'd30);
    do_reset(0, 100, 2, 2, 3);
    bus.in_spike = 4'b0011;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++; if (bus.v_mem !== 16'(exp_v[k])) begin errors++; $display("FAIL if_v[%0d] got %0d want %0d", k, bus.v_mem, exp_v[k]); end
      checks++; if (bus.o_wait !== exp_w[k]) begin errors++; $display("FAIL if_wait[%0d] got %b want %b", k, bus.o_wait, exp_w[k]); end
      checks++; if (bus.out_spike !== exp_o[k]) begin errors++; $display("FAIL if_out[%0d] got %b want %b", k, bus.out_spike, exp_o[k]); end
    end
  endtask

  // Distinct per-channel weights check lane ordering and signed add.
  task automatic test_mixed();
    set_w(8'd5, 8'd20, 8'hFD, 8'd10);  // ch3=5 ch2=20 ch1=-3 ch0=10
    do_reset(0, 1000, 1, 0, 0);
    bus.in_spike = 4'b0110; tick();
    checks++; if (bus.v_mem !== 16'd16) begin errors++; $display("FAIL mix0 got %0d want 16", bus.v_mem); end
    bus.in_spike = 4'b1001; tick();
    checks++; if (bus.v_mem !== 16'd30) begin errors++; $display("FAIL mix1 got %0d want 30", bus.v_mem); end
    bus.in_spike = 4'b0000; tick();
    checks++; if (bus.v_mem !== 16'd29) begin errors++; $display("FAIL mix2 got %0d want 29", bus.v_mem); end
  endtask

  task automatic test_clamp();
    set_w(8'hCE, 8'hCE, 8'hCE, 8'hCE);  // -50 each
    do_reset(10, 100, 2, 0, 0);
    bus.in_spike = 4'b1111;
    for (int k = 0; k < 3; k++) tick();
    checks++; if (bus.v_mem !== 16'd10) begin errors++; $display("FAIL clamp_lo got %0d want 10", bus.v_mem); end
    checks++; if (bus.o_wait !== 1'b0 || bus.out_spike !== 1'b0) begin errors++; $display("FAIL clamp_lo_fire got wait=%b out=%b want 0 0", bus.o_wait, bus.out_spike); end
    set_w(8'd127, 8'd127, 8'd127, 8'd127);
    do_reset(0, 65535, 0, 0, 0);
    bus.in_spike = 4'b1111;
    for (int k = 0; k < 129; k++) tick();
    checks++; if (bus.v_mem !== 16'd65532 || bus.o_wait !== 1'b0) begin errors++; $display("FAIL clamp_hi_pre got v=%0d wait=%b want 65532 0", bus.v_mem, bus.o_wait); end
    tick();  // 65532+508 saturates to 65535 >= V_th
    checks++; if (bus.v_mem !== 16'd0 || bus.o_wait !== 1'b1 || bus.out_spike !== 1'b1) begin errors++; $display("FAIL clamp_hi_fire got v=%0d wait=%b out=%b want 0 1 1", bus.v_mem, bus.o_wait, bus.out_spike); end
  endtask

  // Fires every other tick; only fires at ticks 0, 10, 20 find the slot free.
  task automatic test_overrun();
    int pulses = 0;
    set_w(8'd127, 8'd127, 8'd127, 8'd127);
    do_reset(0, 100, 0, 0, 10);
    bus.in_spike = 4'b1111;
    for (int k = 0; k < 22; k++) begin
      tick();
      if (bus.out_spike === 1'b1) pulses++;
      checks++; if (bus.out_spike !== ((k == 10) || (k == 20))) begin errors++; $display("FAIL ovr_out[%0d] got %b", k, bus.out_spike); end
      checks++; if (bus.o_ovr !== (k >= 2)) begin errors++; $display("FAIL ovr_flag[%0d] got %b want %b", k, bus.o_ovr, (k >= 2)); end
    end
    checks++; if (pulses !== 2) begin errors++; $display("FAIL ovr_count got %0d want 2", pulses); end
  endtask

  task automatic test_kill();
    set_w(8'd30, 8'd30, 8'd30, 8'd30);
    do_reset(0, 100, 2, 0, 5);
    bus.in_spike = 4'b0011;
    for (int k = 0; k < 4; k++) tick();  // fire at tick 1, v=58 after tick 3
    checks++; if (bus.v_mem !== 16'd58) begin errors++; $display("FAIL kill_pre got %0d want 58", bus.v_mem); end
    bus.kill = 1'b1; tick(); bus.kill = 1'b0;
    for (int k = 0; k < 10; k++) begin
      checks++; if (bus.out_spike !== 1'b0 || bus.o_wait !== 1'b0 || bus.v_mem !== 16'd58) begin errors++; $display("FAIL kill[%0d] got out=%b wait=%b v=%0d want 0 0 58", k, bus.out_spike, bus.o_wait, bus.v_mem); end
      tick();
    end
    do_reset(5, 100, 2, 0, 5);
    checks++; if (bus.v_mem !== 16'd5) begin errors++; $display("FAIL kill_rst got %0d want 5", bus.v_mem); end
    bus.in_spike = 4'b0011; tick();
    checks++; if (bus.v_mem !== 16'd63) begin errors++; $display("FAIL kill_active got %0d want 63", bus.v_mem); end
  endtask

  task automatic test_config();
    set_w(8'd25, 8'd25, 8'd25, 8'd25);
    do_reset(0, 100, 0, 0, 0);
    bus.in_spike = 4'b0011;
    bus.cfg_we = 1'b1; bus.V_th = 16'd40;
    tick();  // v_next=50 against old threshold 100
    bus.cfg_we = 1'b0; bus.V_th = 16'd100;
    checks++; if (bus.v_mem !== 16'd50 || bus.o_wait !== 1'b0) begin errors++; $display("FAIL cfg_same got v=%0d wait=%b want 50 0", bus.v_mem, bus.o_wait); end
    tick();  // v_next=100 against latched 40
    checks++; if (bus.v_mem !== 16'd0 || bus.o_wait !== 1'b1) begin errors++; $display("FAIL cfg_next got v=%0d wait=%b want 0 1", bus.v_mem, bus.o_wait); end
  endtask

  initial begin
    rst = 1'b1;
    bus.kill = 1'b0; bus.cfg_we = 1'b0; bus.in_spike = '0; bus.weight = '0;
    bus.V_rest = '0; bus.V_th = '0; bus.V_leak = '0;
    bus.refr_time = '0; bus.axon_delay = '0;
    test_reset();
    test_integrate_fire();
    test_mixed();
    test_clamp();
    test_overrun();
    test_kill();
    test_config();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
